codeword_row_store: RTL
=======================

# codeword_row_store

Eight-row register bank for 19-bit Hamming (19,13) codewords, sitting directly downstream of the 3-to-8 row decoder. It consumes the decoder's one-hot row select and writes or reads one codeword per cycle through a request/valid handshake. It tracks per-row occupancy and runs a sequential clear sweep. Read data feeds the syndrome/correction stage.

## Interface
- `WIDTH`, 19, codeword width in bits
- `ROWS`, 8, number of rows; must match decoder output width

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `row_select`  in  ROWS  one-hot row select from the row decoder
- `wr_req`  in  1  write `wr_data` into the selected row
- `wr_data`  in  WIDTH  codeword to store
- `rd_req`  in  1  read the selected row
- `clr_all`  in  1  start a clear sweep of all rows
- `rd_data`  out  WIDTH  registered read codeword
- `rd_valid`  out  1  one-cycle pulse: `rd_data` is valid
- `rd_empty`  out  1  qualifies `rd_valid`: the row read was unoccupied
- `rd_perr`  out  1  qualifies `rd_valid`: stored parity mismatch
- `sel_err`  out  1  one-cycle pulse: a request arrived with non-one-hot `row_select`
- `row_valid`  out  ROWS  per-row occupancy
- `occ_count`  out  4  number of set bits in `row_valid`
- `busy`  out  1  clear sweep in progress

## Operation
- Reset (`rst_n`=0 at an edge): all row data 0, `row_valid`=0, `occ_count`=0, `rd_data`=0, `rd_valid`=`rd_empty`=`rd_perr`=`sel_err`=0, `busy`=0, FSM in IDLE, sweep counter 0.
- One-hot check:
  - A request is legal only when exactly one bit of `row_select` is set.
  - An illegal request pulses `sel_err` next cycle. It does not write.
  - An illegal read returns `rd_valid`=1, `rd_data`=0, `rd_empty`=1.
- Write: a legal `wr_req` stores `wr_data` into the selected row at the edge and sets that row's `row_valid` bit.
- Read: a legal `rd_req` registers the row contents into `rd_data` and pulses `rd_valid`. `rd_empty` = !row_valid[row] at the request cycle. Reading an empty row returns its stored contents (0 after reset or clear).
- Simultaneous read and write to the same row is read-before-write: `rd_data` returns the old contents, and the new data is stored.
- FSM states IDLE and CLEAR:
  - IDLE→CLEAR on `clr_all` with counter=0.
  - In CLEAR, each cycle zeroes row[counter] and its valid bit, then increments the counter.
  - After clearing row ROWS-1, the FSM returns to IDLE.
- `busy`=1 exactly while in CLEAR. During CLEAR, `wr_req`, `rd_req` and `clr_all` are ignored: no `rd_valid`, no `sel_err`.
- `occ_count` is the registered popcount of next-state `row_valid`, so it always matches `row_valid` in the same cycle.

## Timing
- Write visible to a read issued the next cycle; `row_valid` and `occ_count` update one edge after `wr_req`.
- Read latency: 1 cycle, from `rd_req` sampled to `rd_valid`/`rd_data`.
- `rd_valid` is held for 1 cycle only; `rd_data` holds its value until the next read.
- Clear sweep: `busy` rises 1 cycle after `clr_all` and stays high for exactly ROWS cycles (8). A request in the cycle `clr_all` is sampled is still serviced.
- Reset mid-sweep: the next cycle shows reset values with `busy`=0.

## Configuration
- `ROW_STORE_PARITY_EN` defined:
  - Each row stores one extra even-parity bit computed from `wr_data` on write.
  - A read recomputes parity over the stored codeword; `rd_perr`=1 with `rd_valid` on mismatch.
  - Clear writes parity 0.
- Undefined: no parity storage, and `rd_perr` is tied to 0.

## Structure
- Shared package `hamming_pkg`:
  - constants `CW_WIDTH`=19, `DATA_WIDTH`=13, `NUM_ROWS`=8
  - the FSM state enum (IDLE, CLEAR)
- Sub-module `onehot_check`, purely combinational: `row_select` in; `is_onehot` and 3-bit `row_index` out. Shared with any other decoder consumers.

## Test plan
- Reset, then write 19'h5A5A5 to row 3 (`row_select`=8'h08), read row 3 next cycle → `rd_valid`=1 one cycle later, `rd_data`=19'h5A5A5, `rd_empty`=0, `row_valid`=8'h08, `occ_count`=1.
- Read row 6, never written → `rd_data`=0, `rd_empty`=1.
- Same cycle, write 19'h00001 and read row 3 → `rd_data`=19'h5A5A5; a follow-up read returns 19'h00001.
- `row_select`=8'h00, then 8'h11, each with `wr_req` → `sel_err` pulses twice, `row_valid` unchanged.
- Fill all rows, assert `clr_all` → `busy` high for exactly 8 cycles, `occ_count` decrements 8→0, requests during `busy` produce no response.
- With `ROW_STORE_PARITY_EN`, force one stored bit flipped (bench backdoor), read → `rd_perr`=1. Without the macro → `rd_perr`=0.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared constants and FSM state type for the Hamming (19,13) datapath.
package hamming_pkg;

  localparam int unsigned CW_WIDTH   = 19;
  localparam int unsigned DATA_WIDTH = 13;
  localparam int unsigned NUM_ROWS   = 8;
  localparam int unsigned OCC_W      = 4;

  // Row-store sweep controller states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Even-parity bit over a full codeword
  function automatic logic even_parity(input logic [CW_WIDTH-1:0] cw);
    return ^cw;
  endfunction

endpackage

// File: rtl/onehot_check.sv
// Combinational one-hot validator and binary encoder for a decoder row select.
module onehot_check
  import hamming_pkg::*;
#(
  parameter  int unsigned ROWS  = NUM_ROWS,
  localparam int unsigned IDX_W = $clog2(ROWS)
) (
  input  logic [ROWS-1:0]  row_select,
  output logic             is_onehot,
  output logic [IDX_W-1:0] row_index
);

  logic [IDX_W:0] ones;

  // Count set bits and OR-encode their positions; the index is meaningful only when one-hot
  always_comb begin
    ones      = '0;
    row_index = '0;
    for (int i = 0; i < int'(ROWS); i++) begin
      if (row_select[i]) begin
        ones      = ones + (IDX_W+1)'(1);
        row_index = row_index | IDX_W'(i);
      end
    end
    is_onehot = (ones == (IDX_W+1)'(1));
  end

endmodule

// File: rtl/codeword_row_store.sv
// Eight-row codeword register bank with occupancy tracking and a sequential clear sweep.
// Optional per-row even-parity storage is enabled with ROW_STORE_PARITY_EN.
module codeword_row_store
  import hamming_pkg::*;
#(
  parameter int unsigned WIDTH = CW_WIDTH,
  parameter int unsigned ROWS  = NUM_ROWS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ROWS-1:0]  row_select,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  input  logic             clr_all,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_empty,
  output logic             rd_perr,
  output logic             sel_err,
  output logic [ROWS-1:0]  row_valid,
  output logic [OCC_W-1:0] occ_count,
  output logic             busy
);

  localparam int unsigned IDX_W = $clog2(ROWS);

  logic             is_onehot;
  logic [IDX_W-1:0] row_idx;

  state_e           state_q,    state_d;
  logic [IDX_W-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] mem_q [ROWS];
  logic [WIDTH-1:0] mem_d [ROWS];
  logic [ROWS-1:0]  valid_q,    valid_d;
  logic [OCC_W-1:0] occ_q,      occ_d;
  logic [WIDTH-1:0] rd_data_q,  rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_empty_q, rd_empty_d;
  logic             sel_err_q,  sel_err_d;
  logic             busy_q,     busy_d;
`ifdef ROW_STORE_PARITY_EN
  logic [ROWS-1:0]  par_q,      par_d;
  logic             rd_perr_q,  rd_perr_d;
`endif

  onehot_check #(.ROWS(ROWS)) u_onehot (
    .row_select (row_select),
    .is_onehot  (is_onehot),
    .row_index  (row_idx)
  );

  // Next-state: request servicing in IDLE, one row zeroed per cycle in CLEAR
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    valid_d    = valid_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_empty_d = 1'b0;
    sel_err_d  = 1'b0;
    occ_d      = '0;
`ifdef ROW_STORE_PARITY_EN
    par_d      = par_q;
    rd_perr_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if ((wr_req || rd_req) && !is_onehot) begin
          sel_err_d = 1'b1;
        end
        // Read samples the old contents, so a same-row write is read-before-write
        if (rd_req) begin
          rd_valid_d = 1'b1;
          if (is_onehot) begin
            rd_data_d  = mem_q[row_idx];
            rd_empty_d = !valid_q[row_idx];
`ifdef ROW_STORE_PARITY_EN
            rd_perr_d  = even_parity(CW_WIDTH'(mem_q[row_idx])) != par_q[row_idx];
`endif
          end else begin
            rd_data_d  = '0;
            rd_empty_d = 1'b1;
          end
        end
        if (wr_req && is_onehot) begin
          mem_d[row_idx]   = wr_data;
          valid_d[row_idx] = 1'b1;
`ifdef ROW_STORE_PARITY_EN
          par_d[row_idx]   = even_parity(CW_WIDTH'(wr_data));
`endif
        end
        if (clr_all) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        mem_d[cnt_q]   = '0;
        valid_d[cnt_q] = 1'b0;
`ifdef ROW_STORE_PARITY_EN
        par_d[cnt_q]   = 1'b0;
`endif
        if (cnt_q == IDX_W'(ROWS - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Popcount of next-state occupancy keeps occ_count aligned with row_valid
    for (int i = 0; i < int'(ROWS); i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
    busy_d = (state_d == ST_CLEAR);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      for (int i = 0; i < int'(ROWS); i++) begin
        mem_q[i] <= '0;
      end
      valid_q    <= '0;
      occ_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_empty_q <= 1'b0;
      sel_err_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ROW_STORE_PARITY_EN
      par_q      <= '0;
      rd_perr_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      valid_q    <= valid_d;
      occ_q      <= occ_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_empty_q <= rd_empty_d;
      sel_err_q  <= sel_err_d;
      busy_q     <= busy_d;
`ifdef ROW_STORE_PARITY_EN
      par_q      <= par_d;
      rd_perr_q  <= rd_perr_d;
`endif
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_empty  = rd_empty_q;
  assign sel_err   = sel_err_q;
  assign row_valid = valid_q;
  assign occ_count = occ_q;
  assign busy      = busy_q;
`ifdef ROW_STORE_PARITY_EN
  assign rd_perr   = rd_perr_q;
`else
  assign rd_perr   = 1'b0;
`endif

endmodule
